decade_counter_ctrl: RTL and testbench
======================================

# decade_counter_ctrl

Run controller for a chain of cascaded decade (BCD) counter digits. It takes start, stop and clear commands. It divides the system clock into count ticks with a prescaler and advances a DIGITS-wide BCD count with ripple carry between digits. When the count equals a programmed BCD target it stops and flags completion. It sits between front-panel or bus control strobes and the digit display / decade counter datapath.

## Interface
- DIGITS, 4: number of BCD digits in the chain; must be ≥1.
- PRESCALE, 10: clk cycles per count tick; must be ≥1.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- start  in  1  command strobe, sampled each edge: begin counting or resume.
- stop  in  1  command strobe: pause counting.
- clear  in  1  command strobe: abort and zero the count.
- target  in  4*DIGITS  BCD terminal value; digit i occupies bits [4i+3:4i].
- bcd  out  4*DIGITS  current BCD count, same packing as target.
- running  out  1  high while in RUN.
- done  out  1  high while in DONE.
- tick  out  1  one-cycle pulse, high in the cycle that bcd shows a newly incremented value.

## Operation
- States:
  - IDLE: count zero or holding after clear.
  - RUN
  - PAUSE
  - DONE
- Command priority, evaluated every edge: clear > stop > start. Lower-priority commands in the same cycle are ignored.
- clear, in any state: next state IDLE; bcd=0; prescaler=0; tick=0.
- IDLE + start: go to RUN; prescaler=0; bcd keeps its value, which is 0.
- RUN:
  - The prescaler counts 0..PRESCALE-1.
  - At PRESCALE-1 with no stop or clear: bcd increments, prescaler returns to 0, tick is registered high.
  - RUN + stop: go to PAUSE; the prescaler freezes at its current value and no increment occurs, even if the prescaler was at PRESCALE-1.
- PAUSE + start: go to RUN; the prescaler resumes from its frozen value.
- RUN, when the incremented value equals target: go to DONE on the same edge; bcd holds at target.
- DONE: start and stop are ignored; only clear or reset leaves.
- BCD increment:
  - Digit 0 always advances.
  - Digit i advances only when all lower digits are 9.
  - A digit at 9 wraps to 0.
  - All-9s wraps to all-0s and counting continues.
- Target compare:
  - Full-width equality, checked only against the post-increment value.
  - target=0 is therefore reached only after a full wrap, i.e. 10^DIGITS ticks.
  - A target containing any digit >9 never matches; the counter runs and wraps indefinitely.
- target may change at any time; it is used combinationally at each increment.
- Outputs running and done are decoded directly from registered state. bcd and tick are registers.

## Timing
- Reset, asynchronous and immediate, with no clock edge needed:
  - state=IDLE, bcd=0, prescaler=0
  - running=0, done=0, tick=0
- Reset takes effect mid-RUN and in any state; it must also deassert cleanly with the clock running.
- start sampled on edge N (from IDLE): running=1 after edge N. The first increment occurs at edge N+PRESCALE; tick is high in the cycle after that edge.
- Steady RUN gives one increment every PRESCALE cycles. With PRESCALE=1 the count increments every cycle and tick stays high continuously.
- Terminal increment at edge M: after edge M, done=1, running=0, tick=1 for one cycle, bcd=target.
- stop at edge N: running=0 after edge N; bcd and tick are quiet from then on.
- Resume via start at edge R with frozen prescaler value p: the next increment is at edge R+(PRESCALE-1-p)+1.
- No command is latched across cycles; a strobe must be present at the sampling edge.

## Test plan
(DIGITS=2, PRESCALE=3 throughout.)
- Reset: hold reset=0 with random strobes -> bcd=8'h00, running=0, done=0, tick=0. Assert reset asynchronously mid-RUN at bcd=8'h07 -> all outputs zero before the next clk edge.
- Count to target: target=8'h12, start pulse at edge N -> bcd steps 01..09,10,11,12 at edges N+3, N+6, …, N+36, one tick per step. Done rises and running falls at edge N+36. No further ticks follow.
- Pause/resume: start, stop one cycle after bcd=8'h02 (prescaler=0), hold 10 cycles -> bcd stays 02 with no tick. Then start -> bcd=8'h03 exactly 3 edges after the start edge.
- Stop at terminal prescale: assert stop in the cycle the prescaler=2 -> no increment, PAUSE. Then start -> increment on the first edge after resume.
- Wrap and invalid target:
  - target=8'h00 -> bcd passes 99→00 after 100 ticks, then done=1.
  - target=8'hA5 -> counts past 99 to 00 and continues; done never rises over 250 ticks.
- Priority and DONE: clear+start at the same edge in RUN -> IDLE, bcd=8'h00, running=0. In DONE, start and stop pulses leave done=1 and bcd unchanged; clear -> done=0, bcd=8'h00.

Source files
------------

// File: rtl/decade_counter_ctrl_if.sv
// ---------------------------------------------------------------------------
// decade_counter_ctrl_if
//   Groups the command strobes, the BCD target and the count/status outputs
//   of the decade counter run controller.
//
//   Signals (all synchronous to the controller clock):
//     start, stop, clear  command strobes, sampled on every rising edge
//     target              BCD terminal value, digit i in bits [4i+3:4i]
//     bcd                 current BCD count, same packing as target
//     running             high while the controller is counting
//     done                high once the terminal count has been reached
//     tick                one-cycle pulse with each newly incremented bcd
//
//   Modports:
//     master  the command source (front panel / bus bridge)
//     slave   the controller itself
// ---------------------------------------------------------------------------
interface decade_counter_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  stop;
  logic                  clear;
  logic [4*DIGITS-1:0]   target;
  logic [4*DIGITS-1:0]   bcd;
  logic                  running;
  logic                  done;
  logic                  tick;

  modport master (
    output start, stop, clear, target,
    input  bcd, running, done, tick
  );

  modport slave (
    input  start, stop, clear, target,
    output bcd, running, done, tick
  );
endinterface

// File: rtl/decade_counter_ctrl.sv
// ---------------------------------------------------------------------------
// decade_counter_ctrl
//   Run controller for a chain of cascaded BCD digits. A prescaler divides
//   clk into count ticks; each tick advances the DIGITS-wide BCD count with
//   ripple carry. When the freshly incremented count equals the programmed
//   target the controller stops in DONE until cleared or reset.
//
//   Command priority on every edge: clear > stop > start.
//
//   Ports:
//     clk    system clock, all state changes on the rising edge
//     reset  asynchronous, active-low reset
//     bus    decade_counter_ctrl_if slave modport (strobes, target, status)
//
//   Parameters:
//     DIGITS    number of BCD digits (>= 1)
//     PRESCALE  clk cycles per count tick (>= 1)
// ---------------------------------------------------------------------------
module decade_counter_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  decade_counter_ctrl_if.slave   bus
);

  // A prescaler of 1 still needs a one-bit register to keep the code uniform.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q;
  logic [PW-1:0]         pre_q;
  logic [4*DIGITS-1:0]   bcd_q;
  logic                  tick_q;
  logic [4*DIGITS-1:0]   bcd_inc;

  // Ripple-carry BCD increment: a digit advances only while every digit
  // below it is 9; a digit at 9 wraps to 0 and passes the carry upward.
  // NOTE: combinational blocks use blocking '=' so later statements see the
  // updated carry; every output gets a default first so no latch is inferred.
  always_comb begin : bcd_increment
    logic carry;
    bcd_inc = bcd_q;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (bcd_q[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      bcd_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (bus.clear) begin
        state_q <= S_IDLE;
        pre_q   <= '0;
        bcd_q   <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.start && !bus.stop) begin
              state_q <= S_RUN;
              pre_q   <= '0;
            end
          end
          S_RUN: begin
            if (bus.stop) begin
              // Prescaler freezes where it is, even at its last phase.
              state_q <= S_PAUSE;
            end else if (pre_q == PRE_LAST) begin
              pre_q  <= '0;
              bcd_q  <= bcd_inc;
              tick_q <= 1'b1;
              // A target digit above 9 can never equal a valid BCD count,
              // so an invalid target simply never terminates the run.
              if (bcd_inc == bus.target) begin
                state_q <= S_DONE;
              end
            end else begin
              pre_q <= pre_q + PW'(1);
            end
          end
          S_PAUSE: begin
            if (bus.start && !bus.stop) begin
              state_q <= S_RUN;
            end
          end
          S_DONE: begin
            // Only clear (handled above) or reset leaves DONE.
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.bcd     = bcd_q;
  assign bus.tick    = tick_q;
  assign bus.running = (state_q == S_RUN);
  assign bus.done    = (state_q == S_DONE);

endmodule

// File: tb/tb_decade_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_decade_counter_ctrl
//   Self-checking bench for decade_counter_ctrl with DIGITS=2, PRESCALE=3.
//   A behavioural model tracks the count as a plain integer and the elapsed
//   run cycles since the last tick; every falling edge the DUT outputs are
//   compared against it. Directed sequences add literal expectations, then
//   a randomized phase exercises strobes, target changes and async resets.
// ---------------------------------------------------------------------------
module tb_decade_counter_ctrl;

  localparam int DIGITS   = 2;
  localparam int PRESCALE = 3;
  localparam int W        = 4 * DIGITS;
  localparam int MODULUS  = 10 ** DIGITS;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  decade_counter_ctrl_if #(.DIGITS(DIGITS)) bus ();

  decade_counter_ctrl #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_count = 0;   // count as a plain integer 0..MODULUS-1
  int m_elap  = 0;   // run cycles elapsed since the last tick
  int m_mode  = M_IDLE;
  bit m_tick  = 1'b0;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] b = '0;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  // Decimal value of a BCD target, or -1 when any digit is not a decimal.
  function automatic int tgt_value(input logic [W-1:0] t);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (t[4*i +: 4] > 4'd9) return -1;
      v = v * 10 + int'(t[4*i +: 4]);
    end
    return v;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_count = 0;
      m_elap  = 0;
      m_mode  = M_IDLE;
      m_tick  = 1'b0;
    end else begin
      m_tick = 1'b0;
      if (bus.clear) begin
        m_mode  = M_IDLE;
        m_count = 0;
        m_elap  = 0;
      end else if (bus.stop) begin
        if (m_mode == M_RUN) m_mode = M_PAUSE;
      end else if (bus.start && m_mode == M_IDLE) begin
        m_mode = M_RUN;
        m_elap = 0;
      end else if (bus.start && m_mode == M_PAUSE) begin
        m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
        m_elap++;
        if (m_elap == PRESCALE) begin
          m_elap  = 0;
          m_count = (m_count + 1) % MODULUS;
          m_tick  = 1'b1;
          if (m_count == tgt_value(bus.target)) m_mode = M_DONE;
        end
      end
    end
  end

  // ---------------- cycle-by-cycle comparison ----------------
  always @(negedge clk) begin
    check("bcd",     32'(bus.bcd),     32'(to_bcd(m_count)));
    check("running", 32'(bus.running), 32'(m_mode == M_RUN));
    check("done",    32'(bus.done),    32'(m_mode == M_DONE));
    check("tick",    32'(bus.tick),    32'(m_tick));
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  task automatic wait_bcd(input logic [W-1:0] v, input int budget);
    int n = 0;
    while (bus.bcd !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_bcd", 32'(bus.bcd), 32'(v));
  endtask

  initial begin
    int n;
    int ticks;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.clear  = 1'b0;
    bus.target = 8'h12;

    // Reset held with random strobes.
    repeat (6) begin
      @(negedge clk);
      bus.start = 1'($urandom_range(1));
      bus.stop  = 1'($urandom_range(1));
      bus.clear = 1'($urandom_range(1));
    end
    @(negedge clk);
    check("rst_bcd",     32'(bus.bcd),     32'h00);
    check("rst_running", 32'(bus.running), 32'h0);
    check("rst_done",    32'(bus.done),    32'h0);
    check("rst_tick",    32'(bus.tick),    32'h0);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.clear = 1'b0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);

    // Count to target 12: twelve ticks, done at N+36.
    bus.target = 8'h12;
    pulse_start();                       // now after edge N
    check("run_after_start", 32'(bus.running), 32'h1);
    ticks = 0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (bus.tick) ticks++;
      if (k == 3) begin
        check("first_inc_bcd",  32'(bus.bcd),  32'h01);
        check("first_inc_tick", 32'(bus.tick), 32'h1);
      end
    end
    check("t12_bcd",     32'(bus.bcd),     32'h12);
    check("t12_done",    32'(bus.done),    32'h1);
    check("t12_running", 32'(bus.running), 32'h0);
    check("t12_ticks",   32'(ticks),       32'd12);
    @(negedge clk);
    check("t12_tick_gone", 32'(bus.tick), 32'h0);

    // DONE ignores start and stop.
    pulse_start();
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    repeat (4) @(negedge clk);
    check("done_hold",     32'(bus.done), 32'h1);
    check("done_hold_bcd", 32'(bus.bcd),  32'h12);
    do_clear();
    check("clr_done", 32'(bus.done), 32'h0);
    check("clr_bcd",  32'(bus.bcd),  32'h00);

    // Pause / resume with the prescaler frozen at 0.
    bus.target = 8'h99;
    pulse_start();
    wait_bcd(8'h02, 20);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check("pause_running", 32'(bus.running), 32'h0);
    repeat (10) @(negedge clk);
    check("pause_bcd", 32'(bus.bcd), 32'h02);
    pulse_start();                       // after edge R
    @(negedge clk);
    @(negedge clk);
    check("resume_r2_bcd", 32'(bus.bcd), 32'h02);
    @(negedge clk);
    check("resume_r3_bcd",  32'(bus.bcd),  32'h03);
    check("resume_r3_tick", 32'(bus.tick), 32'h1);

    // Stop in the cycle the prescaler is at its last phase.
    repeat (2) @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check("stop_last_bcd",     32'(bus.bcd),     32'h03);
    check("stop_last_running", 32'(bus.running), 32'h0);
    repeat (3) @(negedge clk);
    pulse_start();
    check("resume_last_hold", 32'(bus.bcd), 32'h03);
    @(negedge clk);
    check("resume_last_bcd",  32'(bus.bcd),  32'h04);
    check("resume_last_tick", 32'(bus.tick), 32'h1);

    // clear beats start on the same edge.
    bus.clear = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.start = 1'b0;
    check("prio_bcd",     32'(bus.bcd),     32'h00);
    check("prio_running", 32'(bus.running), 32'h0);
    repeat (4) @(negedge clk);
    check("prio_idle_bcd", 32'(bus.bcd), 32'h00);

    // Asynchronous reset mid-RUN at 07, visible before the next edge.
    pulse_start();
    wait_bcd(8'h07, 40);
    #1 reset = 1'b0;
    #1;
    check("async_bcd",     32'(bus.bcd),     32'h00);
    check("async_running", 32'(bus.running), 32'h0);
    check("async_done",    32'(bus.done),    32'h0);
    check("async_tick",    32'(bus.tick),    32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("after_rst_running", 32'(bus.running), 32'h0);

    // target 00 is reached only after a full wrap: 100 ticks = 300 edges.
    bus.target = 8'h00;
    pulse_start();
    n = 0;
    while (!bus.done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wrap_edges", 32'(n),       32'd300);
    check("wrap_bcd",   32'(bus.bcd), 32'h00);
    do_clear();

    // Invalid target: counts through the wrap and never finishes.
    bus.target = 8'hA5;
    pulse_start();
    repeat (760) @(negedge clk);
    check("inval_done",    32'(bus.done),    32'h0);
    check("inval_running", 32'(bus.running), 32'h1);
    do_clear();

    // Randomized strobes, targets and asynchronous reset pulses.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.clear = ($urandom_range(63) == 0);
      bus.stop  = ($urandom_range(15) == 0);
      bus.start = ($urandom_range(7) == 0);
      if ($urandom_range(49) == 0) begin
        if ($urandom_range(3) == 0)
          bus.target = W'($urandom);
        else
          bus.target = to_bcd((m_count + int'($urandom_range(1, 6))) % MODULUS);
      end
      if ($urandom_range(299) == 0) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.clear = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
